mem_arbiter: RTL
================

# mem_arbiter

Shares the single backing-memory port between the icache refill path and the dcache refill/writeback path. Each requester is granted a full cache-line burst of BURST_LEN beats. Grants alternate round-robin when both requesters contend. The block sits between the two caches' miss interfaces and the external memory bus; the core pipeline never sees it directly.

## Interface
- ADDR_SIZE, 32, address width in bits
- WORD_SIZE, 32, beat data width in bits (multiple of 8)
- BURST_LEN, 4, beats per line (power of two, ≥2)
- clk_i  in  1  clock
- reset_ni  in  1  reset, asynchronous, active-low
- ic_req_i  in  1  icache line-read request; held until ic_done_o
- ic_addr_i  in  ADDR_SIZE  icache miss address (any byte within the line)
- ic_rd_data_o  out  WORD_SIZE  read beat data
- ic_rd_valid_o  out  1  ic_rd_data_o valid this cycle
- ic_done_o  out  1  one-cycle pulse on the final beat of an icache burst
- dc_req_i  in  1  dcache line request; held until dc_done_o
- dc_write_i  in  1  1 = writeback burst, 0 = refill burst; sampled at grant
- dc_addr_i  in  ADDR_SIZE  dcache line address (any byte within the line)
- dc_wr_data_i  in  WORD_SIZE  write data for beat beat_o
- dc_wr_ready_o  out  1  write beat accepted this cycle
- dc_rd_data_o  out  WORD_SIZE  read beat data
- dc_rd_valid_o  out  1  dc_rd_data_o valid this cycle
- dc_done_o  out  1  one-cycle pulse on the final beat of a dcache burst
- beat_o  out  log2(BURST_LEN)  index of the current beat within the burst
- mem_req_o  out  1  memory request active
- mem_write_o  out  1  1 = write burst
- mem_addr_o  out  ADDR_SIZE  current beat address
- mem_wr_data_o  out  WORD_SIZE  write data
- mem_ack_i  in  1  beat completes this cycle (read data valid / write data taken)
- mem_rd_data_i  in  WORD_SIZE  read data

## Operation
- States:
  - IDLE: no burst in progress.
  - BURST_I: icache burst in progress.
  - BURST_D: dcache burst in progress.
- Registers: state, owner-last (last_d), beat counter, line base, write flag.
- Arbitration happens in IDLE only:
  - If exactly one request is high, grant that requester.
  - If both are high, grant the requester that was not granted last (last_d=1 → icache).
  - last_d resets to 0, so dcache wins the first tie.
- At grant, capture:
  - line base = requester address with its low log2(BURST_LEN·WORD_SIZE/8) bits cleared;
  - beat counter = 0;
  - dc_write_i, for dcache grants only (icache bursts are always reads).
- During a burst:
  - mem_req_o = 1.
  - mem_addr_o = base + beat·(WORD_SIZE/8); arithmetic wraps mod 2^ADDR_SIZE.
  - mem_write_o = the captured write flag.
  - beat_o = beat counter.
- Each cycle with mem_ack_i=1 during a burst: beat counter += 1.
  - Read burst: the owner's rd_valid_o = 1, and the owner's rd_data_o = mem_rd_data_i (combinational pass-through).
  - Write burst: dc_wr_ready_o = 1; mem_wr_data_o = dc_wr_data_i (pass-through, valid whenever in a dcache write burst, else 0).
- Final beat (ack while counter = BURST_LEN−1):
  - the owner's done_o = 1;
  - next state = IDLE;
  - last_d updates to the owner.
- Dropping a request mid-burst has no effect; the burst runs to completion. Requests must be held high through done_o.
- A request that is still high in IDLE after done_o is treated as a new request.
- The non-owner's valid, ready and done outputs stay 0 throughout.
- Outputs are 0 in IDLE: mem_req_o, mem_write_o, mem_addr_o, mem_wr_data_o, beat_o, all valid/ready/done. rd_data outputs are 0 whenever their valid is 0.
- Async reset (any time, including mid-burst): state = IDLE, all registers cleared, all outputs 0 immediately. An interrupted burst is abandoned and is not resumed.

## Timing
- Request sampled in IDLE at edge N → mem_req_o high from cycle N+1 (registered grant).
- Beat latency = memory latency; the block adds zero cycles per beat.
- Burst of BURST_LEN beats with ack held high: BURST_LEN cycles of mem_req_o.
- After done_o, the state is IDLE for exactly one cycle. The earliest next mem_req_o is 2 cycles after the final-ack cycle.
- A minimum burst-to-burst gap of one idle cycle is required; the memory side must tolerate mem_req_o deasserting between bursts.
- mem_ack_i while in IDLE is ignored.

## Test plan
- Lone icache miss, ic_addr_i=0x0000_1234, ack always high:
  - mem_addr_o = 0x1230, 0x1234, 0x1238, 0x123C on consecutive cycles with mem_write_o=0;
  - ic_rd_valid_o on each beat;
  - ic_done_o on the 4th beat.
- Dcache writeback, dc_addr_i=0x2008, dc_wr_data_i = 0xA0+beat_o, ack on alternate cycles:
  - mem_wr_data_o = 0xA0, 0xA1, 0xA2, 0xA3 on ack cycles;
  - dc_wr_ready_o only on ack cycles;
  - dc_done_o after 8 cycles.
- ic_req_i and dc_req_i rise together from reset: order dcache, icache; then, with both held, dcache, icache again. Exactly one idle cycle between bursts.
- ic_req_i dropped after beat 1: all 4 beats still issued. No new grant unless the request is re-raised.
- reset_ni pulsed low at beat 2 of a dcache refill:
  - mem_req_o and beat_o are 0 asynchronously;
  - after release, a held ic_req_i is granted with beat_o=0.
- Line base near top of the address space, addr 0xFFFF_FFF4: addresses 0xFFFF_FFF0…0xFFFF_FFFC with no overflow into bit ADDR_SIZE.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bundles the icache miss port, the dcache miss port and the
// external memory bus that meet at mem_arbiter.
//   slave  - the arbiter's view (requests/addresses/mem ack in, grants/data out)
//   master - the view of the surrounding caches and memory model
// Signal suffixes (_i/_o) are named from the arbiter's side.
interface mem_arbiter_if #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int BURST_LEN = 4
) ();
  localparam int BEAT_W = $clog2(BURST_LEN);

  // icache refill port
  logic                 ic_req_i;
  logic [ADDR_SIZE-1:0] ic_addr_i;
  logic [WORD_SIZE-1:0] ic_rd_data_o;
  logic                 ic_rd_valid_o;
  logic                 ic_done_o;

  // dcache refill / writeback port
  logic                 dc_req_i;
  logic                 dc_write_i;
  logic [ADDR_SIZE-1:0] dc_addr_i;
  logic [WORD_SIZE-1:0] dc_wr_data_i;
  logic                 dc_wr_ready_o;
  logic [WORD_SIZE-1:0] dc_rd_data_o;
  logic                 dc_rd_valid_o;
  logic                 dc_done_o;

  logic [BEAT_W-1:0]    beat_o;

  // external memory bus
  logic                 mem_req_o;
  logic                 mem_write_o;
  logic [ADDR_SIZE-1:0] mem_addr_o;
  logic [WORD_SIZE-1:0] mem_wr_data_o;
  logic                 mem_ack_i;
  logic [WORD_SIZE-1:0] mem_rd_data_i;

  modport slave (
    input  ic_req_i, ic_addr_i,
    output ic_rd_data_o, ic_rd_valid_o, ic_done_o,
    input  dc_req_i, dc_write_i, dc_addr_i, dc_wr_data_i,
    output dc_wr_ready_o, dc_rd_data_o, dc_rd_valid_o, dc_done_o,
    output beat_o,
    output mem_req_o, mem_write_o, mem_addr_o, mem_wr_data_o,
    input  mem_ack_i, mem_rd_data_i
  );

  modport master (
    output ic_req_i, ic_addr_i,
    input  ic_rd_data_o, ic_rd_valid_o, ic_done_o,
    output dc_req_i, dc_write_i, dc_addr_i, dc_wr_data_i,
    input  dc_wr_ready_o, dc_rd_data_o, dc_rd_valid_o, dc_done_o,
    input  beat_o,
    input  mem_req_o, mem_write_o, mem_addr_o, mem_wr_data_o,
    output mem_ack_i, mem_rd_data_i
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single backing-memory port between the icache refill
// path and the dcache refill/writeback path. Each grant is a full line burst
// of BURST_LEN beats; contention is resolved round-robin.
// Ports:
//   clk_i     - clock
//   reset_ni  - asynchronous active-low reset
//   bus       - mem_arbiter_if.slave: icache port, dcache port, memory bus
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | no burst in progress; arbitration happens here
// BURST_I | icache line read in progress
// BURST_D | dcache line read or writeback in progress
module mem_arbiter #(
  parameter int ADDR_SIZE = 32,
  parameter int WORD_SIZE = 32,
  parameter int BURST_LEN = 4
) (
  input logic           clk_i,
  input logic           reset_ni,
  mem_arbiter_if.slave  bus
);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int OFF_W  = $clog2(BURST_LEN * WORD_SIZE / 8);

  localparam logic [BEAT_W-1:0]    LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_SIZE-1:0] BEAT_BYTES = ADDR_SIZE'(WORD_SIZE / 8);
  localparam logic [ADDR_SIZE-1:0] LINE_MASK  =
    ~((ADDR_SIZE'(1) << OFF_W) - ADDR_SIZE'(1));

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] BURST_I = 2'd1;
  localparam logic [1:0] BURST_D = 2'd2;

  logic [1:0]           state_q, state_d;
  logic                 last_d_q, last_d_d;   // 1 = dcache owned the last burst
  logic [BEAT_W-1:0]    beat_q, beat_d;
  logic [ADDR_SIZE-1:0] base_q, base_d;
  logic                 write_q, write_d;

  logic in_i, in_d, busy, beat_ack, last_beat;
  logic pick_ic, pick_dc;

  assign in_i      = (state_q == BURST_I);
  assign in_d      = (state_q == BURST_D);
  assign busy      = in_i | in_d;
  assign beat_ack  = busy & bus.mem_ack_i;
  assign last_beat = (beat_q == LAST_BEAT);

  // On a tie the requester that did not own the previous burst wins.
  assign pick_dc = bus.dc_req_i & (~bus.ic_req_i | ~last_d_q);
  assign pick_ic = bus.ic_req_i & (~bus.dc_req_i |  last_d_q);

  always_comb begin
    state_d  = state_q;
    last_d_d = last_d_q;
    beat_d   = beat_q;
    base_d   = base_q;
    write_d  = write_q;
    case (state_q)
      IDLE: begin
        if (pick_dc) begin
          state_d = BURST_D;
          beat_d  = '0;
          base_d  = bus.dc_addr_i & LINE_MASK;
          write_d = bus.dc_write_i;
        end else if (pick_ic) begin
          state_d = BURST_I;
          beat_d  = '0;
          base_d  = bus.ic_addr_i & LINE_MASK;
          write_d = 1'b0;
        end
      end
      BURST_I, BURST_D: begin
        if (bus.mem_ack_i) begin
          if (last_beat) begin
            state_d  = IDLE;
            last_d_d = in_d;
            beat_d   = '0;
            write_d  = 1'b0;
          end else begin
            beat_d = beat_q + BEAT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= IDLE;
      last_d_q <= 1'b0;
      beat_q   <= '0;
      base_q   <= '0;
      write_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_d_q <= last_d_d;
      beat_q   <= beat_d;
      base_q   <= base_d;
      write_q  <= write_d;
    end
  end

  logic ic_valid, dc_valid, dc_wr_path;

  assign ic_valid   = in_i & bus.mem_ack_i;
  assign dc_valid   = in_d & ~write_q & bus.mem_ack_i;
  assign dc_wr_path = in_d & write_q;

  assign bus.mem_req_o     = busy;
  assign bus.mem_write_o   = dc_wr_path;
  // Sum truncates to ADDR_SIZE, so a line at the top of memory wraps cleanly.
  assign bus.mem_addr_o    = busy ? (base_q + ADDR_SIZE'(beat_q) * BEAT_BYTES) : '0;
  assign bus.mem_wr_data_o = dc_wr_path ? bus.dc_wr_data_i : '0;
  assign bus.beat_o        = busy ? beat_q : '0;

  assign bus.ic_rd_valid_o = ic_valid;
  assign bus.ic_rd_data_o  = ic_valid ? bus.mem_rd_data_i : '0;
  assign bus.ic_done_o     = in_i & bus.mem_ack_i & last_beat;

  assign bus.dc_rd_valid_o = dc_valid;
  assign bus.dc_rd_data_o  = dc_valid ? bus.mem_rd_data_i : '0;
  assign bus.dc_wr_ready_o = dc_wr_path & bus.mem_ack_i;
  assign bus.dc_done_o     = in_d & beat_ack & last_beat;
endmodule
